ifu_fetch: RTL

IFU_FETCH -- requirements
Module: ifu_fetch

---
 rtl/ifu_fetch.sv | 93 +++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: single-outstanding instruction fetch unit feeding the decode stage.
// Rev 1.0 - initial release.
`default_nettype none

module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        imem_resp_err,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        IDU_en,
  input  logic        pc_upd_valid,
  input  logic [31:0] dnpc,
  input  logic        halt,
  output logic        fetch_err,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_EXEC = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t state;

  // Request valid is a pure decode of the state register, so it is high in
  // the very first cycle after reset release.
  assign imem_req_valid = (state == S_REQ);
  assign imem_addr      = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc        <= RESET_PC;
      inst      <= 32'h0;
      IDU_en    <= 1'b0;
      fetch_err <= 1'b0;
      fetch_cnt <= 32'h0;
    end else begin
      IDU_en <= 1'b0;
      case (state)
        S_REQ: begin
          if (imem_req_ready) state <= S_WAIT;
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (imem_resp_err) begin
              fetch_err <= 1'b1;
              state     <= S_HALT;
            end else begin
              inst      <= imem_resp_data;
              IDU_en    <= 1'b1;
              fetch_cnt <= fetch_cnt + 32'd1;
              state     <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          // halt takes priority over any PC update in the same cycle
          if (halt) begin
            state <= S_HALT;
          end else if (pc_upd_valid) begin
            if (dnpc[1:0] == 2'b00) begin
              pc    <= dnpc;
              state <= S_REQ;
            end else begin
              fetch_err <= 1'b1;
              state     <= S_HALT;
            end
          end
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_HALT;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
